// File: rtl/regfile_dump_unit_if.sv
// -----------------------------------------------------------------------------
// regfile_dump_unit_if
// Bundles the register-file read port and the outbound dump stream of
// regfile_dump_unit.
//   rd_en     : read strobe, one cycle per register read
//   rd_sel    : index of the register being read
//   rd_data   : read data, valid exactly one cycle after rd_en
//   out_valid : stream beat valid
//   out_ready : downstream accept
//   out_idx   : index of the beat (63 marks the optional checksum beat)
//   out_data  : beat value
//   out_last  : final beat of a dump
// master = the dump unit, slave = register file plus stream sink.
// -----------------------------------------------------------------------------
interface regfile_dump_unit_if #(
  parameter int DATA_W = 34
);
  logic              rd_en;
  logic [5:0]        rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_idx;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output rd_en, rd_sel,
    input  rd_data,
    output out_valid, out_idx, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_sel,
    output rd_data,
    input  out_valid, out_idx, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_unit.sv
// -----------------------------------------------------------------------------
// regfile_dump_unit
// Walks NUM_REGS register-file entries (32 GPRs then the edge-collision
// registers), reading each one and streaming it out as an index/value beat
// with valid/ready flow control.
//   clk   : single clock, rising edge
//   rstb  : synchronous active-high reset
//   start : one-cycle dump request, honoured only while idle
//   busy  : high while a dump is in progress (low again in the done cycle)
//   done  : one-cycle pulse when a dump completes
//   bus   : regfile_dump_unit_if master (read port + dump stream)
// Optional feature macro: DUMP_CHECKSUM_EN -- appends one beat (idx 63)
// carrying the modulo-2^DATA_W sum of all data beats; that beat carries
// out_last instead of the final register beat.
// -----------------------------------------------------------------------------
module regfile_dump_unit #(
  parameter int NUM_REGS = 38,
  parameter int DATA_W   = 34
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                start,
  output logic                busy,
  output logic                done,
  regfile_dump_unit_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_CAPT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_REGS - 1);

  state_t            state_q;
  logic [5:0]        idx_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [5:0]        rd_sel_q;
  logic              out_valid_q;
  logic [5:0]        out_idx_q;
  logic [DATA_W-1:0] hold_q;
  logic              out_last_q;
  logic              hs_s;

`ifdef DUMP_CHECKSUM_EN
  localparam logic [5:0] CHK_IDX = 6'd63;
  logic [DATA_W-1:0] sum_q;
  logic              chk_beat_q;
`endif

  assign hs_s = out_valid_q & bus.out_ready;

  // Dump sequencer: state, index, holding register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q     <= ST_IDLE;
      idx_q       <= 6'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_sel_q    <= 6'd0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 6'd0;
      hold_q      <= '0;
      out_last_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q       <= '0;
      chk_beat_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q    <= 6'd0;
            busy_q   <= 1'b1;
            rd_en_q  <= 1'b1;
            rd_sel_q <= 6'd0;
            state_q  <= ST_READ;
`ifdef DUMP_CHECKSUM_EN
            sum_q      <= '0;
            chk_beat_q <= 1'b0;
`endif
          end
        end
        ST_READ: begin
          rd_en_q <= 1'b0;
          state_q <= ST_CAPT;
        end
        ST_CAPT: begin
          // The register file answers one cycle after the strobe.
          hold_q      <= bus.rd_data;
          out_idx_q   <= idx_q;
          out_valid_q <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          out_last_q  <= 1'b0;
`else
          out_last_q  <= (idx_q == LAST_IDX);
`endif
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (hs_s) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            if (chk_beat_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else if (idx_q == LAST_IDX) begin
              // Checksum beat follows straight away, still in SEND.
              sum_q       <= sum_q + hold_q;
              hold_q      <= sum_q + hold_q;
              out_idx_q   <= CHK_IDX;
              out_last_q  <= 1'b1;
              out_valid_q <= 1'b1;
              chk_beat_q  <= 1'b1;
            end else begin
              sum_q    <= sum_q + hold_q;
              idx_q    <= idx_q + 6'd1;
              rd_sel_q <= idx_q + 6'd1;
              rd_en_q  <= 1'b1;
              state_q  <= ST_READ;
            end
`else
            if (idx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q    <= idx_q + 6'd1;
              rd_sel_q <= idx_q + 6'd1;
              rd_en_q  <= 1'b1;
              state_q  <= ST_READ;
            end
`endif
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here.
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          rd_en_q     <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_sel    = rd_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_data  = hold_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
module tb_regfile_dump_unit;
  localparam int NR = 38;
  localparam int DW = 34;
`ifdef DUMP_CHECKSUM_EN
  localparam int NBEATS   = NR + 1;
  localparam int LAST_EXP = 63;
`else
  localparam int NBEATS   = NR;
  localparam int LAST_EXP = NR - 1;
`endif

  logic clk   = 1'b0;
  logic rstb  = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  regfile_dump_unit_if #(.DATA_W(DW)) bus ();

  regfile_dump_unit #(.NUM_REGS(NR), .DATA_W(DW)) dut (
    .clk  (clk),
    .rstb (rstb),
    .start(start),
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Register file: answers one cycle after rd_en, garbage otherwise.
  logic [DW-1:0] regs [64];
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= regs[bus.rd_sel];
    else           bus.rd_data <= DW'({$urandom(), $urandom()});
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model: list of beats a dump must produce
  typedef struct {
    logic [5:0]    idx;
    logic [DW-1:0] data;
    bit            last;
    bit            rd;
  } beat_t;

  beat_t mq[$];
  bit    m_active  = 1'b0;
  int    m_next_valid = 0;
  int    m_done_at = -1;
  bit    rst_last  = 1'b0;
  bit    armed     = 1'b0;

  int            rx_cnt = 0, done_cnt = 0, last_cnt = 0;
  logic [5:0]    last_idx;
  logic [DW-1:0] rx_data [64];
  int            start_cyc = 0, first_valid_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  bit            fv_seen = 1'b0;
  logic [5:0]    first_idx;

  always @(negedge clk) begin : compare
    bit    exp_valid;
    bit    exp_rd;
    beat_t b;
`ifdef DUMP_CHECKSUM_EN
    logic [DW-1:0] s;
`endif
    exp_valid = 1'b0;
    exp_rd    = 1'b0;
    cyc++;
    if (rst_last) armed = 1'b1;
    if (armed) begin
      if (rst_last) begin
        check("rst_busy",      64'(busy),          64'(0));
        check("rst_done",      64'(done),          64'(0));
        check("rst_rd_en",     64'(bus.rd_en),     64'(0));
        check("rst_rd_sel",    64'(bus.rd_sel),    64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_last",  64'(bus.out_last),  64'(0));
        check("rst_out_idx",   64'(bus.out_idx),   64'(0));
        check("rst_out_data",  64'(bus.out_data),  64'(0));
      end else begin
        exp_valid = m_active && (mq.size() > 0) && (cyc >= m_next_valid);
        exp_rd    = m_active && (mq.size() > 0) && mq[0].rd && (cyc == m_next_valid - 2);
        check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        if (exp_valid && bus.out_valid) begin
          check("out_idx",  64'(bus.out_idx),  64'(mq[0].idx));
          check("out_data", 64'(bus.out_data), 64'(mq[0].data));
          check("out_last", 64'(bus.out_last), 64'(mq[0].last));
        end
        check("rd_en", 64'(bus.rd_en), 64'(exp_rd));
        if (exp_rd && bus.rd_en) check("rd_sel", 64'(bus.rd_sel), 64'(mq[0].idx));
        check("busy", 64'(busy), 64'(m_active));
        check("done", 64'(done), 64'(cyc == m_done_at));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.out_valid && !fv_seen) begin
        fv_seen = 1'b1;
        first_valid_cyc = cyc;
        first_idx = bus.out_idx;
      end
      // model advance using this cycle's inputs
      if (rstb) begin
        m_active = 1'b0;
        mq.delete();
        m_done_at = -1;
      end else if (!m_active && cyc != m_done_at) begin
        if (start) begin
`ifdef DUMP_CHECKSUM_EN
          s = '0;
`endif
          for (int i = 0; i < NR; i++) begin
            b.idx  = 6'(i);
            b.data = regs[i];
`ifdef DUMP_CHECKSUM_EN
            b.last = 1'b0;
            s = s + regs[i];
`else
            b.last = (i == NR - 1);
`endif
            b.rd   = 1'b1;
            mq.push_back(b);
          end
`ifdef DUMP_CHECKSUM_EN
          b.idx = 6'd63; b.data = s; b.last = 1'b1; b.rd = 1'b0;
          mq.push_back(b);
`endif
          m_active = 1'b1;
          m_next_valid = cyc + 3;
          start_cyc = cyc;
        end
      end else if (exp_valid && bus.out_ready) begin
        rx_data[mq[0].idx] = bus.out_data;
        rx_cnt++;
        if (bus.out_last) begin
          last_cnt++;
          last_idx = bus.out_idx;
        end
        void'(mq.pop_front());
        if (mq.size() > 0) begin
          m_next_valid = mq[0].rd ? cyc + 3 : cyc + 1;
        end else begin
          m_active = 1'b0;
          m_done_at = cyc + 1;
          last_hs_cyc = cyc;
        end
      end
    end
    rst_last = rstb;
  end

  // ---------------- stimulus helpers (main process sits at posedge+1)
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_log();
    rx_cnt = 0; done_cnt = 0; last_cnt = 0; fv_seen = 1'b0;
  endtask

  task automatic wait_valid_idx(input int idx);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_idx == 6'(idx)) found = 1'b1;
    end
    if (!found) timeout_fail("wait_valid_idx");
  endtask

  task automatic wait_done();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    if (!found) timeout_fail("wait_done");
    tick(1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit found;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) regs[i] = DW'(i + 256);
    rstb = 1'b1;
    tick(3);
    rstb = 1'b0;

    // T1: plain dump of idx+0x100
    clear_log();
    pulse_start();
    wait_done();
    tick(2);
    check("t1_beats",      64'(rx_cnt),   64'(NBEATS));
    check("t1_done_cnt",   64'(done_cnt), 64'(1));
    check("t1_beat0",      64'(rx_data[0]),  64'(34'h100));
    check("t1_beat37",     64'(rx_data[37]), 64'(34'h125));
    check("t1_first_lat",  64'(first_valid_cyc - start_cyc), 64'(3));
    check("t1_done_lat",   64'(done_cyc - last_hs_cyc),      64'(1));
    check("t1_last_cnt",   64'(last_cnt), 64'(1));
    check("t1_last_idx",   64'(last_idx), 64'(LAST_EXP));

    // T2: 10-cycle backpressure on beat 5
    clear_log();
    pulse_start();
    wait_valid_idx(4);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    wait_valid_idx(5);
    repeat (9) @(negedge clk);
    check("t2_stall_valid", 64'(bus.out_valid), 64'(1));
    check("t2_stall_idx",   64'(bus.out_idx),   64'(5));
    check("t2_stall_data",  64'(bus.out_data),  64'(34'h105));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done();
    tick(2);
    check("t2_beats",  64'(rx_cnt),      64'(NBEATS));
    check("t2_beat5",  64'(rx_data[5]),  64'(34'h105));
    check("t2_beat6",  64'(rx_data[6]),  64'(34'h106));

    // T3: start re-pulsed mid-dump and during the done cycle
    clear_log();
    pulse_start();
    wait_valid_idx(2);
    @(posedge clk); #1;
    pulse_start();
    wait_valid_idx(20);
    @(posedge clk); #1;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_last) found = 1'b1;
    end
    if (!found) timeout_fail("t3_wait_last");
    @(posedge clk); #1;
    pulse_start();
    tick(6);
    check("t3_beats",    64'(rx_cnt),   64'(NBEATS));
    check("t3_done_cnt", 64'(done_cnt), 64'(1));
    check("t3_idle",     64'(busy),     64'(0));

    // T4: reset while beat 12 is stalled in SEND
    clear_log();
    pulse_start();
    wait_valid_idx(11);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    wait_valid_idx(12);
    @(posedge clk); #1;
    rstb = 1'b1;
    tick(1);
    rstb = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_busy_after_rst",  64'(busy),          64'(0));
    check("t4_valid_after_rst", 64'(bus.out_valid), 64'(0));
    repeat (5) @(negedge clk);
    check("t4_no_done", 64'(done_cnt), 64'(0));
    @(posedge clk); #1;
    clear_log();
    pulse_start();
    wait_done();
    tick(2);
    check("t4_first_idx", 64'(first_idx),  64'(0));
    check("t4_beats",     64'(rx_cnt),     64'(NBEATS));
    check("t4_beat0",     64'(rx_data[0]), 64'(34'h100));

    // T5: full-width value on idx 33
    regs[33] = 34'h2_AAAA_5555;
    clear_log();
    pulse_start();
    wait_done();
    tick(2);
    check("t5_beat33", 64'(rx_data[33]), 64'(34'h2AAAA5555));
    check("t5_beat32", 64'(rx_data[32]), 64'(34'h120));

`ifdef DUMP_CHECKSUM_EN
    // T6: checksum of all-ones data
    for (int i = 0; i < NR; i++) regs[i] = 34'h3_FFFF_FFFF;
    clear_log();
    pulse_start();
    wait_done();
    tick(2);
    check("t6_chk_data", 64'(rx_data[63]), 64'(34'h3FFFFFFDA));
    check("t6_last_idx", 64'(last_idx),    64'(63));
    check("t6_last_cnt", 64'(last_cnt),    64'(1));
`endif

    // T7: random data, random backpressure, random start/reset
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < NR; i++) regs[i] = DW'({$urandom(), $urandom()});
      for (int c = 0; c < 500; c++) begin
        bus.out_ready = ($urandom_range(0, 9) < 7);
        start = ($urandom_range(0, 29) == 0);
        rstb  = ($urandom_range(0, 599) == 0);
        tick(1);
      end
      start = 1'b0;
      rstb  = 1'b0;
      bus.out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
        @(negedge clk);
        if (!busy) found = 1'b1;
      end
      if (!found) timeout_fail("t7_wait_idle");
      tick(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
